// File: rtl/stoch_pkg.sv
// Shared types and sizing helpers for the signed stochastic matrix multiplier.
package stoch_pkg;

  // Threshold selection: SUM emits a bit per unit of residual, AVG per NUM_MID units.
  typedef enum logic {
    MODE_SUM = 1'b0,
    MODE_AVG = 1'b1
  } mode_e;

  // Width of the intermediate residual C + D: wide enough that it never overflows.
  function automatic int x_width(input int cnt_w, input int vec_len);
    return cnt_w + $clog2(vec_len + 1) + 1;
  endfunction

endpackage

// File: rtl/stoch_signed_dot_prod.sv
// Counter-based signed stochastic dot product: sums all per-term products into a
// saturating residual and emits at most one signed output bit per cycle.
module stoch_signed_dot_prod
  import stoch_pkg::*;
#(
  parameter int VEC_LEN = 2,
  parameter int CNT_W   = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  input  logic               CLR,
  input  logic               MODE,
  input  logic [VEC_LEN-1:0] u_p,
  input  logic [VEC_LEN-1:0] u_n,
  input  logic [VEC_LEN-1:0] v_p,
  input  logic [VEC_LEN-1:0] v_n,
  output logic               y_p,
  output logic               y_n,
  output logic               sat
);

  localparam int XW = x_width(CNT_W, VEC_LEN);
  localparam logic signed [XW-1:0] C_MAX = XW'((2 ** (CNT_W - 1)) - 1);
  localparam logic signed [XW-1:0] C_MIN = XW'(-(2 ** (CNT_W - 1)));

  mode_e                   mode;
  logic signed [CNT_W-1:0] c;
  logic signed [CNT_W-1:0] c_nxt;
  logic signed [XW-1:0]    d;
  logic signed [XW-1:0]    x;
  logic signed [XW-1:0]    thr;
  logic signed [XW-1:0]    r;
  logic                    yp_nxt;
  logic                    yn_nxt;
  logic                    clamp;

  assign mode = mode_e'(MODE);

  // Dot product, threshold decision and residual saturation for this cycle.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    d      = '0;
    yp_nxt = 1'b0;
    yn_nxt = 1'b0;
    clamp  = 1'b0;
    // A term is nonzero only when both rails of each operand differ; the sign is
    // positive when both operands carry the same polarity.
    for (int k = 0; k < VEC_LEN; k++) begin
      if ((u_p[k] ^ u_n[k]) & (v_p[k] ^ v_n[k])) begin
        d = (u_p[k] == v_p[k]) ? d + XW'(1) : d - XW'(1);
      end
    end
    thr = (mode == MODE_AVG) ? XW'(VEC_LEN) : XW'(1);
    x   = XW'(c) + d;
    r   = x;
    if (x >= thr) begin
      yp_nxt = 1'b1;
      r      = x - thr;
    end else if (x <= -thr) begin
      yn_nxt = 1'b1;
      r      = x + thr;
    end
    c_nxt = CNT_W'(r);
    if (r > C_MAX) begin
      c_nxt = CNT_W'(C_MAX);
      clamp = 1'b1;
    end else if (r < C_MIN) begin
      c_nxt = CNT_W'(C_MIN);
      clamp = 1'b1;
    end
  end

  // Residual, output bits and sticky saturation flag; CLR outranks EN.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: state is written with non-blocking assignments so all registers update together.
    if (RST) begin
      c   <= '0;
      y_p <= 1'b0;
      y_n <= 1'b0;
      sat <= 1'b0;
    end else if (CLR) begin
      c   <= '0;
      y_p <= 1'b0;
      y_n <= 1'b0;
      sat <= 1'b0;
    end else if (EN) begin
      c   <= c_nxt;
      y_p <= yp_nxt;
      y_n <= yn_nxt;
      sat <= sat | clamp;
    end else begin
      y_p <= 1'b0;
      y_n <= 1'b0;
    end
  end

endmodule

// File: rtl/stoch_signed_matrix_mult.sv
// Signed stochastic matrix multiplier: one dot-product unit per output element.
module stoch_signed_matrix_mult
  import stoch_pkg::*;
#(
  parameter int NUM_ROWS = 2,
  parameter int NUM_MID  = 2,
  parameter int NUM_COLS = 2,
  parameter int CNT_W    = 8
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               EN,
  input  logic                               CLR,
  input  logic                               MODE,
  input  logic [NUM_ROWS-1:0][NUM_MID-1:0]   A_p,
  input  logic [NUM_ROWS-1:0][NUM_MID-1:0]   A_n,
  input  logic [NUM_MID-1:0][NUM_COLS-1:0]   B_p,
  input  logic [NUM_MID-1:0][NUM_COLS-1:0]   B_n,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0]  Y_p,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0]  Y_n,
  output logic                               SAT
);

  // Columns of B, so each unit sees a contiguous vector.
  logic [NUM_COLS-1:0][NUM_MID-1:0] bt_p;
  logic [NUM_COLS-1:0][NUM_MID-1:0] bt_n;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0] sat_e;

  for (genvar k = 0; k < NUM_MID; k++) begin : g_tk
    for (genvar j = 0; j < NUM_COLS; j++) begin : g_tj
      assign bt_p[j][k] = B_p[k][j];
      assign bt_n[j][k] = B_n[k][j];
    end
  end

  for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row
    for (genvar j = 0; j < NUM_COLS; j++) begin : g_col
      stoch_signed_dot_prod #(
        .VEC_LEN (NUM_MID),
        .CNT_W   (CNT_W)
      ) u_dot (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .CLR  (CLR),
        .MODE (MODE),
        .u_p  (A_p[i]),
        .u_n  (A_n[i]),
        .v_p  (bt_p[j]),
        .v_n  (bt_n[j]),
        .y_p  (Y_p[i][j]),
        .y_n  (Y_n[i][j]),
        .sat  (sat_e[i][j])
      );
    end
  end

  assign SAT = |sat_e;

endmodule

// File: doc/stoch_signed_matrix_mult.md
# stoch_signed_matrix_mult

Signed, runtime-scalable stochastic matrix multiplier for bitstream datapaths. Each operand element is a signed stochastic bitstream carried on a positive and a negative channel. Each output element comes from a counter-based signed dot-product unit that folds all per-term products into a residual accumulator, so the sum is exact instead of OR-approximated. Sits between stochastic operand generators and downstream stochastic arithmetic or bitstream-to-value estimators.

## Interface

**Parameters**
- NUM_ROWS, 2, rows of A and Y
- NUM_MID, 2, inner dimension (columns of A, rows of B)
- NUM_COLS, 2, columns of B and Y
- CNT_W, 8, signed residual counter width per output element; must be ≥ $clog2(NUM_MID+1)+2

**Ports**
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  asynchronous, active-high reset
- EN  in  1  consume input bits this cycle
- CLR  in  1  synchronous clear of counters, outputs and SAT
- MODE  in  1  0 = SUM (threshold 1), 1 = AVG (threshold NUM_MID); sampled every cycle
- A_p, A_n  in  [NUM_ROWS][NUM_MID]  positive/negative channel bits of A
- B_p, B_n  in  [NUM_MID][NUM_COLS]  positive/negative channel bits of B
- Y_p, Y_n  out  [NUM_ROWS][NUM_COLS]  registered positive/negative output bits
- SAT  out  1  sticky flag, any residual counter saturated since reset/CLR

## Operation

- Per element (i,j), each cycle with EN=1:
  - D = Σ_k (A_p[i][k]−A_n[i][k])·(B_p[k][j]−B_n[k][j]); each term ∈ {−1,0,1}, so D ∈ [−NUM_MID, NUM_MID].
  - Threshold T = 1 (SUM) or NUM_MID (AVG). X = C + D, computed at CNT_W+$clog2(NUM_MID+1)+1 bits, no overflow.
  - X ≥ T: Y_p=1, Y_n=0, C' = X−T.
  - X ≤ −T: Y_p=0, Y_n=1, C' = X+T.
  - Otherwise: Y_p=Y_n=0, C' = X.
  - C' saturates to [−2^(CNT_W−1), 2^(CNT_W−1)−1]. Any clamp sets SAT.
- Y_p and Y_n are never both 1 for the same element.
- EN=0: C holds; Y_p=Y_n=0 next cycle; SAT holds.
- CLR=1: C=0, Y=0, SAT=0 next cycle regardless of EN. CLR wins over EN.
- A_p and A_n both 1 is legal and encodes 0 for that cycle. Same for B.
- MODE change mid-stream is legal; the new threshold applies to the same cycle's X. C is not rescaled.

## Timing

- Latency: 1 cycle. Inputs sampled at edge n drive Y at edge n (visible in cycle n+1).
- RST asserted: C=0, Y_p=Y_n=0, SAT=0 immediately (asynchronous), including mid-stream. The first edge after deassertion processes normally.
- Throughput: one result bit per element per cycle. No stall or backpressure beyond EN.
- SAT rises in the cycle after the clamping edge and stays high until RST or CLR.

## Structure

- Package stoch_pkg: mode_e enum (MODE_SUM=0, MODE_AVG=1); function for the X width.
- Sub-module stoch_signed_dot_prod (params VEC_LEN, CNT_W), one per (i,j) via generate:
  - inputs u_p, u_n (row of A); v_p, v_n (column of B); EN, CLR, MODE
  - outputs y_p, y_n, sat
- Top level transposes B combinationally (continuous assignment, no latch) and ORs per-element sat into SAT.

## Test plan

All scenarios use 2×2×2 and CNT_W=8 unless stated.

- **Reset mid-stream:** run random streams 10 cycles, assert RST between edges → Y_p, Y_n, SAT read 0 immediately; after release with all-zero inputs, Y stays 0.
- **SUM identity:** A_p=I, B_p=all 1, MODE=0, EN=1 → D=1 everywhere, Y_p=all 1 every cycle from the first edge, C stays 0.
- **AVG half-rate:** MODE=1, A_p=all 1, B_p row 0 = 1 and row 1 = 0 → D=1, T=2, Y_p per element = 0,1,0,1,…, starting 0.
- **Sign cancellation:** A_p=all 1, B_p row 0 = 1, B_n row 1 = 1 → D=0, Y_p=Y_n=0 forever. Negating A (A_n instead) with B_n only → Y_p=all 1.
- **Saturation:** CNT_W=4, MODE=0, A_p=B_p=all 1 → D=2, C climbs by 1 per cycle to 7. The eighth edge clamps, SAT=1 from the following cycle, Y_p stays 1. CLR → SAT=0, C=0.
- **EN/CLR priority:** EN=0 for 3 cycles with D=1 in AVG mode and C=1 → Y=0, C stays 1; re-enable → Y_p=1 on the first edge. Assert CLR and EN together → Y=0 and C=0 next cycle.
